stepgen_sched: RTL and testbench
================================

// Module: stepgen_sched
// PURPOSE
//  Host-side controller for a bank of N stepgen channels. Double-buffers the
//  per-channel velocity and the shared dirtime/steptime/tap/enable values
//  written over the SPI register bus. Applies all of them on one clock edge
//  when the host commits, and snapshots every channel's position on that edge.
//  A watchdog forces all motion to stop if the host stops committing.
// PARAMETERS
//  N        4        number of stepgen channels
//  W        12       integer position bits (matches stepgen W)
//  F        10       fractional bits; velocity is F+1 bits (matches stepgen F)
//  T        5        dirtime/steptime width (matches stepgen T)
//  WD_W     20       watchdog counter width
//  WD_LIMIT 1000000  RUN cycles without commit before fault; 0 disables watchdog
// PORTS
//  clk         in   1          system clock; also clocks the stepgen bank
//  rst_n       in   1          asynchronous active-low reset
//  wr_stb      in   1          one-cycle register write strobe
//  wr_addr     in   4          0..N-1 velocity ch; 8 timing; 9 control
//  wr_data     in   16         write data
//  commit      in   1          one-cycle request: apply shadow, snapshot positions
//  fault_clr   in   1          clears watchdog fault
//  position_i  in   N*(W+F)    channel positions from stepgen bank, ch0 in LSBs
//  velocity_o  out  N*(F+1)    active velocities to stepgen bank
//  dirtime_o   out  T          active dirtime (all channels)
//  steptime_o  out  T          active steptime (all channels)
//  tap_o       out  2          active tap select
//  enable_o    out  1          stepgen enable
//  pos_snap    out  N*(W+F)    positions captured at the last apply
//  commit_ack  out  1          one-cycle pulse: apply done, pos_snap valid
//  wdt_fault   out  1          sticky watchdog fault
// BEHAVIOUR
//  Reset: all shadow/active registers and pos_snap = 0; all outputs 0; state IDLE.
//  Shadow writes: when wr_stb=1, the target register updates at that edge.
//   Writes are accepted in every state, including FAULT.
//   - addr<N: vel_sh[addr] <= wr_data[F:0].
//   - addr 8: dirtime_sh <= [T-1:0]; steptime_sh <= [T+7:8]; tap_sh <= [15:14].
//   - addr 9: en_sh <= [0].
//   - Other addresses are ignored.
//  States: IDLE, APPLY, RUN, FAULT (2-bit encoding).
//   - IDLE/RUN + commit=1 -> APPLY.
//   - APPLY (exactly 1 cycle), at its ending edge:
//     - all active outputs <= shadow; enable_o <= en_sh.
//     - pos_snap <= position_i; watchdog cleared.
//     - next state = RUN if en_sh else IDLE.
//   - RUN: watchdog increments each cycle. When count == WD_LIMIT-1 and
//     commit=0 -> FAULT.
//   - FAULT, on entry edge: enable_o <= 0; velocity_o <= 0; wdt_fault <= 1.
//     dirtime/steptime/tap are held. Commits are ignored in FAULT.
//   - FAULT + fault_clr=1 -> IDLE; wdt_fault <= 0.
//  Latency: commit high in cycle k -> APPLY in cycle k+1 -> new outputs and
//   commit_ack=1 in cycle k+2.
//  Write in the same cycle as commit: included in the apply.
//   Write during the APPLY cycle: stays in shadow for the next commit.
//  Commit during APPLY: dropped; no ack is generated for it.
//  Commit and watchdog expiry in the same cycle: commit wins (APPLY).
//  fault_clr outside FAULT: no effect.
//  Watchdog: saturating; never wraps. It does not count in IDLE.
//  Reset asserted mid-APPLY: outputs return to 0 asynchronously; no ack.
// STRUCTURE
//  stepgen_pkg: state encoding, register address constants (ADDR_VEL_MAX,
//   ADDR_TIMING=8, ADDR_CTRL=9), timing field bit positions.
//  Sub-module stepgen_wdt:
//   - inputs: clk, rst_n, run, clear.
//   - output: expire (combinational, count==WD_LIMIT-1 && run; tied 0 when WD_LIMIT=0).
//  The shadow/active register bank and FSM live in stepgen_sched itself.
// TESTING (N=4, F=10, T=5, WD_LIMIT=16)
//  1. Reset, then idle: all outputs 0, state IDLE, no commit_ack.
//  2. Write vel ch2=11'h040, addr8=16'h4305, addr9=1, then commit:
//     - ack 2 cycles after commit; enable_o=1; velocity_o ch2=0x040.
//     - dirtime_o=5; steptime_o=3; tap_o=1.
//     - pos_snap equals position_i sampled in the APPLY cycle.
//  3. Commit with a ch0 write in the same cycle -> new ch0 applied.
//     Write ch1 during APPLY -> not applied until the next commit.
//  4. RUN with no commit for 16 cycles -> wdt_fault=1, enable_o=0, velocity_o=0.
//     Then commit -> no ack. Then fault_clr -> IDLE, fault cleared.
//  5. Commit in the cycle the watchdog would expire -> APPLY, no fault.
//     Commit during APPLY -> exactly one ack.
//  6. Pulse rst_n low in the APPLY cycle -> outputs 0 at once, no ack, IDLE.

Source files
------------

// File: rtl/stepgen_pkg.sv
// Shared definitions for the stepgen scheduler: FSM encoding, register map, timing-word fields.
// No logic. No latency. No backpressure.
package stepgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam logic [3:0] ADDR_VEL_MAX = 4'd7;
  localparam logic [3:0] ADDR_TIMING  = 4'd8;
  localparam logic [3:0] ADDR_CTRL    = 4'd9;

  localparam int DIR_LSB  = 0;
  localparam int STEP_LSB = 8;
  localparam int TAP_LSB  = 14;
  localparam int EN_BIT   = 0;

endpackage

// File: rtl/stepgen_wdt.sv
// Saturating watchdog: counts while run is high, expire is combinational on the last allowed cycle.
// Latency: expire in the same cycle the count reaches WD_LIMIT-1. No backpressure.
module stepgen_wdt #(
  parameter int WD_W     = 20,
  parameter int WD_LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam logic [WD_W-1:0] LIMIT_M1 = WD_W'(WD_LIMIT - 1);

  logic [WD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != '1)) begin
      cnt_d = cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero limit disables the watchdog entirely.
  assign expire = (WD_LIMIT != 0) && run && (cnt_q == LIMIT_M1);

endmodule

// File: rtl/stepgen_sched.sv
// Double-buffered stepgen control: shadow registers applied atomically on commit, with watchdog stop.
// Latency: commit in cycle k -> new outputs and commit_ack in cycle k+2. No backpressure; commits during APPLY/FAULT are dropped.
module stepgen_sched
  import stepgen_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 12,
  parameter int F        = 10,
  parameter int T        = 5,
  parameter int WD_W     = 20,
  parameter int WD_LIMIT = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_stb,
  input  logic [3:0]           wr_addr,
  input  logic [15:0]          wr_data,
  input  logic                 commit,
  input  logic                 fault_clr,
  input  logic [N*(W+F)-1:0]   position_i,
  output logic [N*(F+1)-1:0]   velocity_o,
  output logic [T-1:0]         dirtime_o,
  output logic [T-1:0]         steptime_o,
  output logic [1:0]           tap_o,
  output logic                 enable_o,
  output logic [N*(W+F)-1:0]   pos_snap,
  output logic                 commit_ack,
  output logic                 wdt_fault
);

  state_e state_q, state_d;

  logic [N*(F+1)-1:0] vel_sh_q, vel_q;
  logic [T-1:0]       dir_sh_q, step_sh_q, dir_q, step_q;
  logic [1:0]         tap_sh_q, tap_q;
  logic               en_sh_q, en_q;
  logic [N*(W+F)-1:0] snap_q;
  logic               ack_q, fault_q;
  logic               wdt_expire;
  logic               enter_fault;
  logic               unused_wr;

  assign unused_wr = ^wr_data;

  stepgen_wdt #(
    .WD_W     (WD_W),
    .WD_LIMIT (WD_LIMIT)
  ) u_wdt (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state_q == ST_RUN),
    .clear  (state_q == ST_APPLY),
    .expire (wdt_expire)
  );

  // Shadow bank accepts writes in every state; APPLY copies the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vel_sh_q  <= '0;
      dir_sh_q  <= '0;
      step_sh_q <= '0;
      tap_sh_q  <= '0;
      en_sh_q   <= 1'b0;
    end else if (wr_stb) begin
      for (int i = 0; i < N; i++) begin
        if ((wr_addr == 4'(i)) && (wr_addr <= ADDR_VEL_MAX)) begin
          vel_sh_q[i*(F+1) +: F+1] <= wr_data[F:0];
        end
      end
      if (wr_addr == ADDR_TIMING) begin
        dir_sh_q  <= wr_data[DIR_LSB +: T];
        step_sh_q <= wr_data[STEP_LSB +: T];
        tap_sh_q  <= wr_data[TAP_LSB +: 2];
      end
      if (wr_addr == ADDR_CTRL) begin
        en_sh_q <= wr_data[EN_BIT];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (commit) state_d = ST_APPLY;
      ST_APPLY: state_d = en_sh_q ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (commit) begin
          state_d = ST_APPLY;
        end else if (wdt_expire) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: if (fault_clr) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign enter_fault = (state_q == ST_RUN) && (state_d == ST_FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vel_q   <= '0;
      dir_q   <= '0;
      step_q  <= '0;
      tap_q   <= '0;
      en_q    <= 1'b0;
      snap_q  <= '0;
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      ack_q <= (state_q == ST_APPLY);
      if (state_q == ST_APPLY) begin
        vel_q  <= vel_sh_q;
        dir_q  <= dir_sh_q;
        step_q <= step_sh_q;
        tap_q  <= tap_sh_q;
        en_q   <= en_sh_q;
        snap_q <= position_i;
      end else if (enter_fault) begin
        // Stop motion but keep timing so the stepgen pulse shape is unchanged.
        vel_q   <= '0;
        en_q    <= 1'b0;
        fault_q <= 1'b1;
      end else if ((state_q == ST_FAULT) && fault_clr) begin
        fault_q <= 1'b0;
      end
    end
  end

  assign velocity_o = vel_q;
  assign dirtime_o  = dir_q;
  assign steptime_o = step_q;
  assign tap_o      = tap_q;
  assign enable_o   = en_q;
  assign pos_snap   = snap_q;
  assign commit_ack = ack_q;
  assign wdt_fault  = fault_q;

endmodule

// File: tb/tb_stepgen_sched.sv
// Bench for stepgen_sched: directed scenarios plus random traffic against a transaction-level model.
module tb_stepgen_sched;

  localparam int N   = 4;
  localparam int W   = 12;
  localparam int F   = 10;
  localparam int T   = 5;
  localparam int LIM = 16;
  localparam int PW  = N*(W+F);
  localparam int VW  = N*(F+1);
  localparam int OW  = VW + T + T + 2 + 1 + PW + 1 + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_stb = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic          commit = 1'b0;
  logic          fault_clr = 1'b0;
  logic [PW-1:0] position_i = '0;
  logic [VW-1:0] velocity_o;
  logic [T-1:0]  dirtime_o, steptime_o;
  logic [1:0]    tap_o;
  logic          enable_o, commit_ack, wdt_fault;
  logic [PW-1:0] pos_snap;

  stepgen_sched #(.N(N), .W(W), .F(F), .T(T), .WD_W(20), .WD_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .fault_clr(fault_clr), .position_i(position_i),
    .velocity_o(velocity_o), .dirtime_o(dirtime_o), .steptime_o(steptime_o), .tap_o(tap_o),
    .enable_o(enable_o), .pos_snap(pos_snap), .commit_ack(commit_ack), .wdt_fault(wdt_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  wire [OW-1:0] obs = {velocity_o, dirtime_o, steptime_o, tap_o, enable_o, pos_snap, commit_ack, wdt_fault};

  // Reference model: host-visible register values plus a few flags describing
  // where the commit protocol currently stands.
  logic [F:0]    mv_sh [N];
  logic [F:0]    mv    [N];
  logic [T-1:0]  md_sh, ms_sh, md, ms;
  logic [1:0]    mt_sh, mt;
  logic          me_sh, me, mack, mfault;
  logic [PW-1:0] msnap;
  bit            applying, running, faulted;
  int            run_cnt;

  function automatic logic [OW-1:0] expv();
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[i*(F+1) +: F+1] = mv[i];
    return {v, md, ms, mt, me, msnap, mack, mfault};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv_sh[i] = '0;
      mv[i] = '0;
    end
    md_sh = '0; ms_sh = '0; md = '0; ms = '0; mt_sh = '0; mt = '0;
    me_sh = 1'b0; me = 1'b0; mack = 1'b0; mfault = 1'b0; msnap = '0;
    applying = 0; running = 0; faulted = 0; run_cnt = 0;
  endtask

  task automatic model_step(input bit stb, input logic [3:0] a, input logic [15:0] d,
                            input bit cm, input bit clr);
    mack = applying;
    if (applying) begin
      for (int i = 0; i < N; i++) mv[i] = mv_sh[i];
      md = md_sh; ms = ms_sh; mt = mt_sh; me = me_sh;
      msnap = position_i;
      applying = 0;
      running = me_sh;
      run_cnt = 0;
    end else if (faulted) begin
      if (clr) begin
        faulted = 0;
        mfault = 1'b0;
      end
    end else if (cm) begin
      applying = 1;
      running = 0;
    end else if (running) begin
      run_cnt++;
      if (run_cnt == LIM) begin
        faulted = 1; mfault = 1'b1; running = 0; me = 1'b0;
        for (int i = 0; i < N; i++) mv[i] = '0;
      end
    end
    if (stb) begin
      if (a < N) mv_sh[a] = d[F:0];
      else if (a == 4'd8) begin
        md_sh = d[4:0]; ms_sh = d[12:8]; mt_sh = d[15:14];
      end else if (a == 4'd9) me_sh = d[0];
    end
  endtask

  task automatic cyc(input bit stb, input logic [3:0] a, input logic [15:0] d,
                     input bit cm, input bit clr);
    wr_stb = stb; wr_addr = a; wr_data = d; commit = cm; fault_clr = clr;
    position_i = PW'({$urandom(), $urandom(), $urandom()});
    model_step(stb, a, d, cm, clr);
    @(posedge clk);
    #1;
    wr_stb = 1'b0; commit = 1'b0; fault_clr = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_outputs got=%h want=0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 4'($urandom_range(0, 15)), 16'($urandom()), 1'b0, 1'b0);
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL idle_after_reset got=%h want=%h", obs, expv()); end
    end
    checks++;
    if (commit_ack !== 1'b0) begin failures++; $display("FAIL idle_no_ack got=%b want=0", commit_ack); end
  endtask

  task automatic test_apply();
    cyc(1'b1, 4'd2, 16'h0040, 1'b0, 1'b0);
    cyc(1'b1, 4'd8, 16'h4305, 1'b0, 1'b0);
    cyc(1'b1, 4'd9, 16'h0001, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 16'h0000, 1'b1, 1'b0);
    checks++;
    if (commit_ack !== 1'b0) begin failures++; $display("FAIL apply_early_ack got=%b want=0", commit_ack); end
    cyc(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
    checks++;
    if (commit_ack !== 1'b1) begin failures++; $display("FAIL apply_ack got=%b want=1", commit_ack); end
    checks++;
    if (enable_o !== 1'b1) begin failures++; $display("FAIL apply_enable got=%b want=1", enable_o); end
    checks++;
    if (velocity_o[2*(F+1) +: F+1] !== 11'h040) begin
      failures++; $display("FAIL apply_vel_ch2 got=%h want=040", velocity_o[2*(F+1) +: F+1]);
    end
    checks++;
    if ({dirtime_o, steptime_o, tap_o} !== {5'd5, 5'd3, 2'd1}) begin
      failures++; $display("FAIL apply_timing got=%0d/%0d/%0d want=5/3/1", dirtime_o, steptime_o, tap_o);
    end
    checks++;
    if (pos_snap !== position_i) begin failures++; $display("FAIL apply_snap got=%h want=%h", pos_snap, position_i); end
    checks++;
    if (obs !== expv()) begin failures++; $display("FAIL apply_model got=%h want=%h", obs, expv()); end
  endtask

  task automatic test_same_cycle_write();
    logic [F:0] v0, v1, old1;
    v0 = 11'($urandom());
    old1 = mv_sh[1];
    v1 = 11'($urandom());
    if (v1 == old1) v1 = ~old1;
    cyc(1'b1, 4'd0, 16'(v0), 1'b1, 1'b0);
    cyc(1'b1, 4'd1, 16'(v1), 1'b0, 1'b0);
    checks++;
    if (velocity_o[0 +: F+1] !== v0) begin failures++; $display("FAIL samecyc_ch0 got=%h want=%h", velocity_o[0 +: F+1], v0); end
    checks++;
    if (velocity_o[F+1 +: F+1] !== old1) begin failures++; $display("FAIL apply_wr_ch1 got=%h want=%h", velocity_o[F+1 +: F+1], old1); end
    cyc(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (velocity_o[F+1 +: F+1] !== v1) begin failures++; $display("FAIL next_commit_ch1 got=%h want=%h", velocity_o[F+1 +: F+1], v1); end
    checks++;
    if (obs !== expv()) begin failures++; $display("FAIL samecyc_model got=%h want=%h", obs, expv()); end
  endtask

  task automatic test_watchdog();
    int acks;
    for (int i = 1; i < LIM; i++) begin
      cyc(1'b0, 4'd0, 16'h0, 1'b0, (i == 3));
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL wdt_run c%0d got=%h want=%h", i, obs, expv()); end
    end
    checks++;
    if (wdt_fault !== 1'b0) begin failures++; $display("FAIL wdt_early got=%b want=0", wdt_fault); end
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    checks++;
    if ({wdt_fault, enable_o} !== 2'b10 || velocity_o !== '0) begin
      failures++; $display("FAIL wdt_fault got=f%b e%b v%h want=f1 e0 v0", wdt_fault, enable_o, velocity_o);
    end
    checks++;
    if ({dirtime_o, steptime_o, tap_o} !== {md, ms, mt}) begin failures++; $display("FAIL wdt_timing_held got=%h want=%h", {dirtime_o, steptime_o, tap_o}, {md, ms, mt}); end
    acks = 0;
    cyc(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      acks += int'(commit_ack);
      cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    end
    checks++;
    if (acks != 0 || wdt_fault !== 1'b1) begin failures++; $display("FAIL fault_commit acks=%0d fault=%b want=0/1", acks, wdt_fault); end
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
    checks++;
    if (wdt_fault !== 1'b0) begin failures++; $display("FAIL fault_clr got=%b want=0", wdt_fault); end
    cyc(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (commit_ack !== 1'b1 || obs !== expv()) begin failures++; $display("FAIL post_clr_commit got=%h want=%h", obs, expv()); end
  endtask

  task automatic test_commit_at_expiry();
    int acks;
    for (int i = 1; i < LIM; i++) cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
    checks++;
    if (wdt_fault !== 1'b0 || commit_ack !== 1'b0) begin failures++; $display("FAIL expiry_commit fault=%b ack=%b want=0/0", wdt_fault, commit_ack); end
    acks = 0;
    cyc(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      acks += int'(commit_ack);
      cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    end
    checks++;
    if (acks != 1) begin failures++; $display("FAIL apply_commit_drop acks=%0d want=1", acks); end
    checks++;
    if (obs !== expv()) begin failures++; $display("FAIL expiry_model got=%h want=%h", obs, expv()); end
  endtask

  task automatic test_reset_mid_apply();
    cyc(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
    position_i = PW'({$urandom(), $urandom(), $urandom()});
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL midapply_reset got=%h want=0", obs); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (commit_ack !== 1'b0 || obs !== '0) begin failures++; $display("FAIL midapply_no_ack got=%h want=0", obs); end
    cyc(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (commit_ack !== 1'b1 || obs !== expv()) begin failures++; $display("FAIL midapply_recover got=%h want=%h", obs, expv()); end
  endtask

  task automatic test_random();
    bit stb, cm, clr;
    for (int c = 0; c < 500; c++) begin
      stb = ($urandom_range(0, 1) == 1);
      cm  = (c < 250) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 24) == 0);
      clr = ($urandom_range(0, 7) == 0);
      cyc(stb, 4'($urandom_range(0, 15)), 16'($urandom()), cm, clr);
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL random c%0d got=%h want=%h", c, obs, expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_apply();
    test_same_cycle_write();
    test_watchdog();
    test_commit_at_expiry();
    test_reset_mid_apply();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
